// File: rtl/prog_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_counter_pkg
// Description : Shared op encoding and command priority decode for prog_counter.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_counter_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_INC    = 3'd1,
    OP_BRANCH = 3'd2,
    OP_LOAD   = 3'd3,
    OP_CALL   = 3'd4,
    OP_RET    = 3'd5
  } op_e;

  // Fixed priority: return > call > load > branch > increment > hold.
  function automatic op_e decode_op(input logic i_ret, input logic i_call,
                                    input logic i_load, input logic i_branch,
                                    input logic i_inc);
    if (i_ret)         return OP_RET;
    else if (i_call)   return OP_CALL;
    else if (i_load)   return OP_LOAD;
    else if (i_branch) return OP_BRANCH;
    else if (i_inc)    return OP_INC;
    else               return OP_HOLD;
  endfunction

  // Address bits needed to index a stack of the given depth (at least one).
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_counter_if
// Description : Command and status bundle between a sequencer and prog_counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_counter_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] PC_in;
  logic [WIDTH-1:0] PC_offset;
  logic             PC_load;
  logic             PC_branch;
  logic             PC_increment;
  logic             PC_call;
  logic             PC_return;
  logic [WIDTH-1:0] PC_out;
  logic [DW-1:0]    STACK_depth;
  logic             STACK_full;
  logic             STACK_empty;
  logic             STACK_err;

  modport master (
    output PC_in, PC_offset, PC_load, PC_branch, PC_increment, PC_call, PC_return,
    input  PC_out, STACK_depth, STACK_full, STACK_empty, STACK_err
  );

  modport slave (
    input  PC_in, PC_offset, PC_load, PC_branch, PC_increment, PC_call, PC_return,
    output PC_out, STACK_depth, STACK_full, STACK_empty, STACK_err
  );

endinterface
`default_nettype wire

// File: rtl/prog_counter_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : ret_stack
// Description : Return-address LIFO; only the depth count is reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ret_stack
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         i_push,
  input  wire logic                         i_pop,
  input  wire logic [WIDTH-1:0]             i_data,
  output logic      [WIDTH-1:0]             o_data,
  output logic      [$clog2(DEPTH+1)-1:0]   o_depth,
  output logic                              o_full,
  output logic                              o_empty
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = idx_bits(DEPTH);

  logic [WIDTH-1:0] r_mem [0:(1<<IW)-1];
  logic [DW-1:0]    r_depth;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_rd_idx;
  logic             w_do_push;
  logic             w_do_pop;

  // The depth count doubles as the write pointer; the top sits one below it.
  assign w_wr_idx  = r_depth[IW-1:0];
  assign w_rd_idx  = w_wr_idx - IW'(1);
  assign o_full    = (r_depth == DW'(DEPTH));
  assign o_empty   = (r_depth == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[w_rd_idx];
  assign o_depth   = r_depth;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_depth <= '0;
    end else if (w_do_push) begin
      r_depth <= r_depth + DW'(1);
    end else if (w_do_pop) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
// Module      : prog_counter
// Description : Program counter with branch, load, call/return and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int STEP        = 1,
  parameter int DEPTH       = 4,
  parameter int RESET_VALUE = 0
) (
  input  wire logic     clock,
  input  wire logic     reset,
  prog_counter_if.slave bus
);

  localparam int               DW     = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] c_step = WIDTH'(STEP);

  logic [WIDTH-1:0] r_pc;
  logic             r_err;
  op_e              w_op;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_top;
  logic [DW-1:0]    w_depth;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_err_set;

  assign w_op     = decode_op(bus.PC_return, bus.PC_call, bus.PC_load,
                              bus.PC_branch, bus.PC_increment);
  assign w_pc_inc = r_pc + c_step;

  // A rejected call/return only flags the error; PC and stack stay put.
  always_comb begin
    w_pc_next = r_pc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    case (w_op)
      OP_RET: begin
        if (w_empty) begin
          w_err_set = 1'b1;
        end else begin
          w_pc_next = w_top;
          w_pop     = 1'b1;
        end
      end
      OP_CALL: begin
        if (w_full) begin
          w_err_set = 1'b1;
        end else begin
          w_pc_next = bus.PC_in;
          w_push    = 1'b1;
        end
      end
      OP_LOAD:   w_pc_next = bus.PC_in;
      OP_BRANCH: w_pc_next = r_pc + bus.PC_offset;
      OP_INC:    w_pc_next = w_pc_inc;
      default:   w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc  <= WIDTH'(RESET_VALUE);
      r_err <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_data  (w_top),
    .o_depth (w_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.PC_out      = r_pc;
  assign bus.STACK_depth = w_depth;
  assign bus.STACK_full  = w_full;
  assign bus.STACK_empty = w_empty;
  assign bus.STACK_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_counter
// Description : Directed and randomized checks of prog_counter against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_counter;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Reference state: PC value, return addresses as a queue, sticky error.
  logic [15:0] m_pc;
  logic [15:0] m_stack[$];
  logic        m_err;

  prog_counter_if #(.WIDTH(16), .DEPTH(4)) bus ();

  prog_counter #(
    .WIDTH       (16),
    .STEP        (1),
    .DEPTH       (4),
    .RESET_VALUE (0)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_step(input logic rs, input logic ret, input logic call,
                            input logic ld, input logic br, input logic inc,
                            input logic [15:0] pin, input logic [15:0] poff);
    if (rs) begin
      m_pc = 16'h0000;
      m_stack.delete();
      m_err = 1'b0;
    end else if (ret) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else m_pc = m_stack.pop_back();
    end else if (call) begin
      if (m_stack.size() == 4) m_err = 1'b1;
      else begin
        m_stack.push_back(m_pc + 16'd1);
        m_pc = pin;
      end
    end else if (ld) begin
      m_pc = pin;
    end else if (br) begin
      m_pc = m_pc + poff;
    end else if (inc) begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  // Apply one cycle of commands; returns #1 after the sampling edge.
  task automatic cyc(input logic rs, input logic ret, input logic call,
                     input logic ld, input logic br, input logic inc,
                     input logic [15:0] pin, input logic [15:0] poff);
    reset            = rs;
    bus.PC_return    = ret;
    bus.PC_call      = call;
    bus.PC_load      = ld;
    bus.PC_branch    = br;
    bus.PC_increment = inc;
    bus.PC_in        = pin;
    bus.PC_offset    = poff;
    @(posedge clock);
    model_step(rs, ret, call, ld, br, inc, pin, poff);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 1, 1, 1, 1, 16'h1234, 16'h0001);
    n_checks++;
    if (bus.PC_out !== 16'h0000) begin
      n_fail++; $display("FAIL reset_pc: got %h expected 0000", bus.PC_out);
    end
    n_checks++;
    if (bus.STACK_depth !== 3'd0) begin
      n_fail++; $display("FAIL reset_depth: got %0d expected 0", bus.STACK_depth);
    end
    n_checks++;
    if ({bus.STACK_empty, bus.STACK_full, bus.STACK_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got empty/full/err %b expected 100",
               {bus.STACK_empty, bus.STACK_full, bus.STACK_err});
    end
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
      n_checks++;
      if (bus.PC_out !== 16'(i)) begin
        n_fail++; $display("FAIL inc_%0d: got %h expected %h", i, bus.PC_out, 16'(i));
      end
    end
    cyc(0, 0, 0, 1, 0, 0, 16'hFFFF, 16'h0);
    cyc(0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
    n_checks++;
    if (bus.PC_out !== 16'h0000 || bus.STACK_err !== 1'b0) begin
      n_fail++;
      $display("FAIL inc_wrap: got pc %h err %b expected 0000 0", bus.PC_out, bus.STACK_err);
    end
  endtask

  task automatic test_branch();
    cyc(0, 0, 0, 1, 0, 0, 16'h0010, 16'h0);
    cyc(0, 0, 0, 0, 1, 0, 16'h0, 16'hFFF8);
    n_checks++;
    if (bus.PC_out !== 16'h0008) begin
      n_fail++; $display("FAIL branch_back: got %h expected 0008", bus.PC_out);
    end
    cyc(0, 0, 0, 0, 1, 0, 16'h0, 16'h0004);
    n_checks++;
    if (bus.PC_out !== 16'h000C) begin
      n_fail++; $display("FAIL branch_fwd: got %h expected 000c", bus.PC_out);
    end
  endtask

  task automatic test_call_return();
    cyc(0, 0, 0, 1, 0, 0, 16'h0100, 16'h0);
    cyc(0, 0, 1, 0, 0, 0, 16'h0200, 16'h0);
    n_checks++;
    if (bus.PC_out !== 16'h0200 || bus.STACK_depth !== 3'd1) begin
      n_fail++;
      $display("FAIL call: got pc %h depth %0d expected 0200 1", bus.PC_out, bus.STACK_depth);
    end
    cyc(0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
    n_checks++;
    if (bus.PC_out !== 16'h0101 || bus.STACK_depth !== 3'd0 || bus.STACK_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL return: got pc %h depth %0d empty %b expected 0101 0 1",
               bus.PC_out, bus.STACK_depth, bus.STACK_empty);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] ret_exp [4];
    ret_exp[0] = 16'h0031; ret_exp[1] = 16'h0021;
    ret_exp[2] = 16'h0011; ret_exp[3] = 16'h0001;
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 0, 0, 0, 16'(i * 16), 16'h0);
    n_checks++;
    if (bus.PC_out !== 16'h0040 || bus.STACK_full !== 1'b1 || bus.STACK_err !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got pc %h full %b err %b expected 0040 1 1",
               bus.PC_out, bus.STACK_full, bus.STACK_err);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
      n_checks++;
      if (bus.PC_out !== ret_exp[i]) begin
        n_fail++; $display("FAIL lifo_%0d: got %h expected %h", i, bus.PC_out, ret_exp[i]);
      end
    end
  endtask

  task automatic test_priority();
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    cyc(0, 0, 0, 1, 0, 0, 16'h0077, 16'h0);
    cyc(0, 1, 0, 1, 1, 1, 16'h5555, 16'h0010);
    n_checks++;
    if (bus.PC_out !== 16'h0077 || bus.STACK_err !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_nofall: got pc %h err %b expected 0077 1", bus.PC_out, bus.STACK_err);
    end
    cyc(0, 0, 0, 1, 0, 1, 16'h1234, 16'h0);
    n_checks++;
    if (bus.PC_out !== 16'h1234) begin
      n_fail++; $display("FAIL load_over_inc: got %h expected 1234", bus.PC_out);
    end
  endtask

  task automatic test_reset_midseq();
    cyc(0, 0, 1, 0, 0, 0, 16'h0055, 16'h0);
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    cyc(0, 1, 0, 0, 0, 0, 16'h0, 16'h0);
    n_checks++;
    if (bus.PC_out !== 16'h0000 || bus.STACK_depth !== 3'd0 || bus.STACK_err !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midseq: got pc %h depth %0d err %b expected 0000 0 1",
               bus.PC_out, bus.STACK_depth, bus.STACK_err);
    end
  endtask

  task automatic test_random();
    logic rs, ret, call, ld, br, inc;
    cyc(1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 400; i++) begin
      rs   = ($urandom_range(0, 49) == 0);
      ret  = ($urandom_range(0, 4) == 0);
      call = ($urandom_range(0, 3) == 0);
      ld   = ($urandom_range(0, 5) == 0);
      br   = ($urandom_range(0, 3) == 0);
      inc  = ($urandom_range(0, 1) == 0);
      cyc(rs, ret, call, ld, br, inc, 16'($urandom), 16'($urandom));
      n_checks++;
      if (bus.PC_out !== m_pc || bus.STACK_depth !== 3'(m_stack.size()) ||
          bus.STACK_err !== m_err || bus.STACK_full !== (m_stack.size() == 4) ||
          bus.STACK_empty !== (m_stack.size() == 0)) begin
        n_fail++;
        $display("FAIL rand_%0d: got pc %h depth %0d err %b full %b empty %b expected pc %h depth %0d err %b",
                 i, bus.PC_out, bus.STACK_depth, bus.STACK_err, bus.STACK_full,
                 bus.STACK_empty, m_pc, m_stack.size(), m_err);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_pc     = 16'h0;
    m_err    = 1'b0;
    test_reset();
    test_increment();
    test_branch();
    test_call_return();
    test_overflow();
    test_priority();
    test_reset_midseq();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: PC and data width in bits, 2 or more.
REQ-002 SHALL have parameter STEP, default 1: increment amount, 1 to 2^WIDTH-1.
REQ-003 SHALL have parameter DEPTH, default 4: return-address stack entries, 1 to 16.
REQ-004 SHALL have parameter RESET_VALUE, default 0: PC value after reset.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 PC_in  input  WIDTH  absolute target for load and call.
REQ-009 PC_offset  input  WIDTH  two's-complement relative branch offset.
REQ-010 PC_load  input  1  load PC_in.
REQ-011 PC_branch  input  1  add PC_offset to PC.
REQ-012 PC_increment  input  1  add STEP to PC.
REQ-013 PC_call  input  1  push return address, jump to PC_in.
REQ-014 PC_return  input  1  pop stack top into PC.
REQ-015 PC_out  output  WIDTH  current PC, registered.
REQ-016 STACK_depth  output  clog2(DEPTH+1)  number of valid stack entries.
REQ-017 STACK_full / STACK_empty  output  1 each  depth==DEPTH / depth==0, combinational from registered depth.
REQ-018 STACK_err  output  1  sticky flag for overflow or underflow.

Function
REQ-019 SHALL update all state only on rising edge of clock; PC_out SHALL reflect a command one cycle after it is sampled.
REQ-020 SHALL resolve simultaneous commands by fixed priority: return > call > load > branch > increment > hold; lower-priority commands in that cycle SHALL be ignored.
REQ-021 Hold (no command asserted) SHALL keep PC and stack unchanged.
REQ-022 Increment SHALL set PC <= (PC + STEP) mod 2^WIDTH; wrap from max to low values is silent.
REQ-023 Branch SHALL set PC <= (PC + PC_offset) mod 2^WIDTH, with PC_offset interpreted as signed.
REQ-024 Load SHALL set PC <= PC_in.
REQ-025 Call with stack not full SHALL push (PC + STEP) mod 2^WIDTH, set PC <= PC_in, and increment depth.
REQ-026 Call with stack full SHALL leave PC and stack unchanged and set STACK_err.
REQ-027 Return with stack not empty SHALL set PC <= top entry and decrement depth.
REQ-028 Return with stack empty SHALL leave PC unchanged and set STACK_err.
REQ-029 STACK_err SHALL remain set until reset; a failed call or return SHALL NOT fall through to a lower-priority command.
REQ-030 Stack SHALL be strict LIFO; entries above depth SHALL be don't-care and never observable.

Reset
REQ-031 reset high at a clock edge SHALL set PC_out=RESET_VALUE, STACK_depth=0, STACK_empty=1, STACK_full=0, STACK_err=0, overriding all commands.
REQ-032 Reset asserted mid-sequence (for example, between call and return) SHALL discard all stack contents; a subsequent return SHALL underflow.
REQ-033 SHALL leave stack storage un-reset; only depth and pointer SHALL be reset.

Structure
REQ-034 Shared package prog_counter_pkg SHALL hold the op enum (OP_HOLD, OP_INC, OP_BRANCH, OP_LOAD, OP_CALL, OP_RET) and the priority-decode function.
REQ-035 The LIFO SHALL be a sub-module ret_stack (parameters WIDTH, DEPTH; push, pop, data in/out, depth, full, empty).
REQ-036 Top level SHALL contain the PC register, next-PC adder/mux, and error flag only.

Verification (WIDTH=16, STEP=1, DEPTH=4, RESET_VALUE=0)
REQ-037 reset, then 3 cycles PC_increment -> PC_out 0,1,2,3; load 0xFFFF then increment -> 0x0000, STACK_err=0.
REQ-038 PC=0x0010, branch offset 0xFFF8 -> 0x0008; branch offset 0x0004 -> 0x000C.
REQ-039 PC=0x0100, call PC_in=0x0200 -> PC=0x0200, depth=1; return -> PC=0x0101, depth=0, empty=1.
REQ-040 5 calls to 0x10,0x20,0x30,0x40,0x50 from PC=0 -> fifth ignored, PC=0x40, full=1, err=1; 4 returns -> 0x31,0x21,0x11,0x01.
REQ-041 load, branch, increment and return all asserted with depth=0 -> PC unchanged, err=1; load and increment together -> PC=PC_in.
REQ-042 call, then reset, then return -> PC=0, depth=0, err=1.
